fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined 32-bit MIPS core. It owns the program counter and the IF/ID pipeline register and drives the Harvard instruction-memory read port. It produces `InstrD`/`PCPlus4D` for the decode stage, which returns `PCSrcD`, `PCBranchD` and the jump target. Hazard-unit stall and flush requests are applied here.

## Interface
- `WIDTH`, 32, datapath/PC width
- `Instr_width`, 32, instruction width
- `PCSrcD_width`, 2, redirect select width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `StallF`  in  1  hold PC
- `StallD`  in  1  hold IF/ID register
- `PCSrcD`  in  2  {Jump, Branch&Equal} from decode
- `PCBranchD`  in  WIDTH  branch target from decode
- `JumpTargetD`  in  WIDTH  jump target {PCPlus4D[31:28], InstrD[25:0], 2'b00} from decode
- `ImemRD`  in  Instr_width  instruction-memory read data, combinational on `PCF`
- `PCF`  out  WIDTH  current fetch PC; drives instruction-memory address
- `InstrD`  out  Instr_width  IF/ID instruction
- `PCPlus4D`  out  WIDTH  IF/ID PC+4
- `ValidD`  out  1  IF/ID holds a real, non-flushed instruction
- `FetchCount`  out  32  number of instructions accepted into IF/ID

## Operation
- `PCPlus4F = PCF + 4`, modulo 2^WIDTH. 0xFFFF_FFFC + 4 = 0.
- Redirect is `PCSrcD[0] | PCSrcD[1]`, qualified by `ValidD & ~StallD`. The resulting signal is `RedirectD`.
- Next-PC priority:
  - `PCSrcD[1]` selects `JumpTargetD`.
  - Otherwise `PCSrcD[0]` selects `PCBranchD`.
  - Otherwise `PCPlus4F` is used.
  - An unqualified `PCSrcD` is ignored, and `PCPlus4F` is used.
- PC register:
  - `RST` loads `RESET_PC`.
  - Else if `StallF=1`, hold.
  - Else load next-PC.
- IF/ID register, in priority order:
  - `RST`: `InstrD=0` (nop), `PCPlus4D=0`, `ValidD=0`.
  - Else `StallD=1`: hold all fields. A flush is not applied while stalled.
  - Else `RedirectD=1`: flush, which writes `InstrD=0`, `PCPlus4D=0`, `ValidD=0`.
  - Else `StallF=1` with `StallD=0`: insert a bubble (`InstrD=0`, `ValidD=0`), so the held fetch is not duplicated.
  - Else capture `ImemRD`, `PCPlus4F`, and `ValidD=1`.
- `FetchCount`:
  - Reset to 0.
  - Increments by 1 on each cycle in which IF/ID captures with `ValidD` becoming 1.
  - Wraps from 0xFFFF_FFFF to 0.
- `PCF` low two bits: the block passes them through unchanged and does not check alignment.

## Timing
- Reset values: `PCF=RESET_PC`, `InstrD=0`, `PCPlus4D=0`, `ValidD=0`, `FetchCount=0`.
- First fetch: the instruction at `RESET_PC` appears on `InstrD` with `ValidD=1` in the first cycle after `RST` deasserts.
- Fetch-to-decode latency: 1 cycle.
- Redirect:
  - A qualified redirect in cycle n sets `PCF` to the target in cycle n+1.
  - The wrong-path instruction fetched in cycle n is squashed, so `ValidD=0` in n+1.
  - The target instruction is in `InstrD` in cycle n+2. The branch penalty is 1 cycle.
- `StallF` and `StallD` both high: PC and IF/ID are frozen and `FetchCount` is unchanged.
- `RST` asserted mid-operation takes effect at the next edge and overrides stall and redirect.
- Back-to-back redirects: each qualified redirect is handled independently. A redirect cannot originate from a flushed (`ValidD=0`) slot.

## Test plan
- Reset with `RESET_PC=0`, `ImemRD=mem[PCF>>2]`, no stalls, run 4 cycles after reset -> `PCF` = 0x4, 0x8, 0xC, 0x10; `InstrD`=mem[0..3] with `PCPlus4D`=0x4..0x10; `ValidD=1`; `FetchCount` = 1..4.
- With `InstrD` valid, drive `PCSrcD=2'b01`, `PCBranchD=0x40` for 1 cycle -> next `PCF=0x40` and `ValidD=0`; the cycle after, `InstrD`=mem[0x10] with `PCPlus4D=0x44`; `FetchCount` does not increment for the flushed slot.
- Drive `PCSrcD=2'b11`, `JumpTargetD=0x100`, `PCBranchD=0x40` -> `PCF=0x100` (jump wins).
- Hold `StallF=StallD=1` for 3 cycles with `PCSrcD=2'b01` -> `PCF`, `InstrD`, `ValidD`, `FetchCount` are unchanged and no redirect occurs. On release, fetch resumes from the held `PCF`.
- `StallF=1`, `StallD=0` for 1 cycle -> `ValidD=0` and `InstrD=0`, then the held instruction is delivered once.
- Preload `PCF=0xFFFF_FFFC` via `RESET_PC` -> next `PCF=0`. Force `FetchCount` to 0xFFFF_FFFF, then one valid capture -> `FetchCount=0`. Assert `RST` during a redirect -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the IF/ID register, redirects on decode-resolved jumps/branches.
// Latency: one cycle from PCF to InstrD; a taken redirect costs one bubble.
// Backpressure: StallF holds the PC, StallD freezes IF/ID; StallF alone inserts a bubble.
module fetch_stage #(
    parameter int                WIDTH        = 32,
    parameter int                Instr_width  = 32,
    parameter int                PCSrcD_width = 2,
    parameter logic [WIDTH-1:0]  RESET_PC     = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    StallF,
    input  logic                    StallD,
    input  logic [PCSrcD_width-1:0] PCSrcD,
    input  logic [WIDTH-1:0]        PCBranchD,
    input  logic [WIDTH-1:0]        JumpTargetD,
    input  logic [Instr_width-1:0]  ImemRD,
    output logic [WIDTH-1:0]        PCF,
    output logic [Instr_width-1:0]  InstrD,
    output logic [WIDTH-1:0]        PCPlus4D,
    output logic                    ValidD,
    output logic [31:0]             FetchCount
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_plus4_f;
    logic [WIDTH-1:0] pc_next;
    logic             redirect_d;

    assign pc_plus4_f = PCF + PC_STEP;

    // A redirect is only honoured from a live, advancing decode slot.
    assign redirect_d = ValidD & ~StallD & (|PCSrcD[1:0]);

    always_comb begin
        pc_next = pc_plus4_f;
        if (redirect_d) begin
            if (PCSrcD[1]) begin
                pc_next = JumpTargetD;
            end else begin
                pc_next = PCBranchD;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= pc_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            InstrD     <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
            FetchCount <= '0;
        end else if (!StallD) begin
            if (redirect_d) begin
                InstrD   <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else if (StallF) begin
                // The PC is held, so the same fetch will be captured next cycle; emit a bubble now.
                InstrD   <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else begin
                InstrD     <= ImemRD;
                PCPlus4D   <= pc_plus4_f;
                ValidD     <= 1'b1;
                FetchCount <= FetchCount + 32'd1;
            end
        end
    end

endmodule
